tlp_tx_arbiter: RTL

Packet-level arbiter that shares the PCIe core's single AXI-Stream TX slave port (axis_slave2) between two TLP sources, running in the pclk_div2 domain.
- Requester 0: audio DMA memory-write TLP generator.
- Requester 1: completion/message TLP generator.

---
 rtl/tlp_tx_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/tlp_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream TX port between
// two TLP sources. Grants cover whole packets, are issued only while the
// link is up, and every packet boundary passes through IDLE.
module tlp_tx_arbiter #(
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned FIRST_GRANT = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              link_up,
  input  logic              s0_tvalid,
  output logic              s0_tready,
  input  logic [DATA_W-1:0] s0_tdata,
  input  logic              s0_tlast,
  input  logic              s0_tuser,
  input  logic              s1_tvalid,
  output logic              s1_tready,
  input  logic [DATA_W-1:0] s1_tdata,
  input  logic              s1_tlast,
  input  logic              s1_tuser,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic              m_tuser,
  output logic              busy,
  output logic              grant_id,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } state_e;

  localparam logic GRANT_RST = (FIRST_GRANT != 0);

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             busy_q,  busy_d;
  logic [CNT_W-1:0] cnt0_q,  cnt0_d;
  logic [CNT_W-1:0] cnt1_q,  cnt1_d;

  // State, grant and packet-counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= GRANT_RST;
      busy_q  <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  // Payload mux follows the registered grant, so m_tdata always carries a
  // real source value; validity is gated separately by the FSM
  always_comb begin
    m_tdata = grant_q ? s1_tdata : s0_tdata;
    m_tlast = grant_q ? s1_tlast : s0_tlast;
    m_tuser = grant_q ? s1_tuser : s0_tuser;
  end

  // Arbitration, handshake steering and end-of-packet bookkeeping
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    m_tvalid  = 1'b0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    case (state_q)
      IDLE: begin
        if (link_up && (s0_tvalid || s1_tvalid)) begin
          if (s0_tvalid && s1_tvalid) begin
            grant_d = ~grant_q;
          end else begin
            grant_d = s1_tvalid;
          end
          state_d = grant_d ? SEND1 : SEND0;
          busy_d  = 1'b1;
        end
      end
      SEND0: begin
        m_tvalid  = s0_tvalid;
        s0_tready = m_tready;
        if (s0_tvalid && m_tready && s0_tlast) begin
          cnt0_d  = cnt0_q + CNT_W'(1);
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      SEND1: begin
        m_tvalid  = s1_tvalid;
        s1_tready = m_tready;
        if (s1_tvalid && m_tready && s1_tlast) begin
          cnt1_d  = cnt1_q + CNT_W'(1);
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy     = busy_q;
  assign grant_id = grant_q;
  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;

endmodule
